mips_control: RTL
=================

MIPS_CONTROL -- requirements
Module: mips_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum number of cycles spent in MEM waiting for mem_ready.
REQ-002 SHALL have port clk, input, 1: clock, rising edge.
REQ-003 SHALL have port arst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port instr_valid, input, 1: instruction word present on opcode/funct.
REQ-005 SHALL have port opcode, input, 6: instr[31:26].
REQ-006 SHALL have port funct, input, 6: instr[5:0].
REQ-007 SHALL have port zero, input, 1: ALU zero flag from the datapath.
REQ-008 SHALL have port mem_ready, input, 1: data-memory access complete.
REQ-009 SHALL have ports reg_write, reg_dest, alu_src, mem_to_reg, pc_src and jump, each output, 1: datapath controls.
REQ-010 SHALL have port alu_control, output, 3: ALU operation.
REQ-011 SHALL have ports mem_read and mem_write, each output, 1: data-memory strobes.
REQ-012 SHALL have port ir_en, output, 1: capture the instruction register.
REQ-013 SHALL have port pc_en, output, 1: advance the PC.
REQ-014 SHALL have port halted, output, 1: sticky error (illegal instruction or memory timeout).
REQ-015 SHALL have port retired_count, output, 32: retired-instruction count.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXEC, MEM, WB and HALT, one state per cycle unless stated otherwise.
REQ-017 SHALL stay in FETCH while instr_valid=0, and SHALL pulse ir_en for 1 cycle and go to DECODE when instr_valid=1.
REQ-018 SHALL register all decoded controls in DECODE and hold them stable until the instruction retires.
REQ-019 SHALL decode opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-020 SHALL map R-type funct to alu_control: add 100000 to 000, sub 100010 to 001, and 100100 to 010, or 100101 to 011, slt 101010 to 101.
REQ-021 SHALL set alu_control to 000 for lw, sw and addi, and to 001 for beq.
REQ-022 SHALL sequence R-type and addi as DECODE, EXEC, WB, FETCH, with reg_dest=1 for R-type, and alu_src=1 for addi.
REQ-023 SHALL sequence lw as DECODE, EXEC, MEM, WB, FETCH, with alu_src=1, mem_to_reg=1 and reg_dest=0.
REQ-024 SHALL sequence sw as DECODE, EXEC, MEM, FETCH, with alu_src=1 and no register write.
REQ-025 SHALL sequence beq as DECODE, EXEC, FETCH, and SHALL drive pc_src equal to zero during the EXEC cycle only.
REQ-026 SHALL sequence j as DECODE, FETCH, with jump=1 in the DECODE cycle.
REQ-027 SHALL keep mem_read (lw) or mem_write (sw) high in MEM until mem_ready=1, and SHALL leave MEM on the cycle mem_ready=1 is sampled.
REQ-028 SHALL assert reg_write in the WB cycle only, exactly 1 cycle.
REQ-029 SHALL pulse pc_en for exactly 1 cycle per retired instruction, in that instruction's last state (WB, MEM, EXEC or DECODE).
REQ-030 SHALL go from DECODE to HALT on an unknown opcode or R-type funct, and SHALL assert no strobes in that cycle.
REQ-031 SHALL go from MEM to HALT when MEM_TIMEOUT consecutive MEM cycles pass with mem_ready=0, with the strobe dropped on entry.
REQ-032 SHALL hold HALT with halted=1 and all strobes low until reset.
REQ-033 SHALL ignore instr_valid outside FETCH.

Reset
REQ-034 SHALL, while arst_n=0, immediately set the state to FETCH and drive every output to 0, including retired_count and halted.
REQ-035 SHALL, on reset asserted mid-instruction (including MEM), abandon the instruction with no pc_en and no reg_write.
REQ-036 SHALL restart operation at the first rising clk edge after arst_n deasserts.

Configuration
REQ-037 SHALL, with MIPS_CTRL_PERF_EN defined, increment retired_count by 1 on each pc_en pulse, wrapping from 0xFFFFFFFF to 0.
REQ-038 SHALL, with MIPS_CTRL_PERF_EN undefined, tie retired_count to 0 and contain no counter logic.

Structure
REQ-039 SHALL take opcode and funct constants, alu_control encodings and the state enumeration from shared package mips_ctrl_pkg.
REQ-040 SHALL place the funct-to-alu_control mapping in combinational sub-module mips_alu_decoder, with no other sub-modules.

Verification
REQ-041 SHALL cover R-type add: opcode 000000, funct 100000 -> ir_en, then alu_control=000 with reg_dest=1, reg_write high 1 cycle in WB, pc_en on the 4th cycle after ir_en.
REQ-042 SHALL cover lw with mem_ready low 3 cycles: -> mem_read high exactly 4 MEM cycles, then WB with mem_to_reg=1 and reg_write=1, retired_count +1 (PERF_EN).
REQ-043 SHALL cover beq with zero=1 and then zero=0: -> pc_src=1 in EXEC of the first, 0 in the second, no reg_write in either.
REQ-044 SHALL cover illegal opcode 111111: -> HALT next cycle, halted=1, no strobes for 20 cycles, and recovery only after an arst_n pulse.
REQ-045 SHALL cover sw with mem_ready never asserted: -> HALT after 16 MEM cycles with mem_write dropped.
REQ-046 SHALL cover arst_n asserted in MEM of lw: -> all outputs 0 immediately, FETCH after release, no reg_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcode/funct
// encodings, ALU operation codes, FSM states, instruction classes and the
// packed bundle of per-instruction datapath controls.
package mips_ctrl_pkg;

  localparam int unsigned ALU_W = 3;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  // Instruction class latched in DECODE to steer the later states
  typedef enum logic [2:0] {
    K_RTYPE, K_LW, K_SW, K_BEQ, K_ADDI, K_J
  } kind_e;

  // Datapath controls held from DECODE until retirement
  typedef struct packed {
    logic             reg_dest;
    logic             alu_src;
    logic             mem_to_reg;
    logic [ALU_W-1:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/mips_control_alu_decoder.sv
// mips_alu_decoder: combinational R-type funct -> ALU operation mapping.
// Ports:
//   funct         in  [5:0]  instr[5:0]
//   alu_control_c out [2:0]  ALU operation for the funct
//   legal_c       out        funct is one of the supported R-type ops
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_control_c,
  output logic             legal_c
);

  always_comb begin
    alu_control_c = ALU_ADD;
    legal_c       = 1'b1;
    case (funct)
      FN_ADD:  alu_control_c = ALU_ADD;
      FN_SUB:  alu_control_c = ALU_SUB;
      FN_AND:  alu_control_c = ALU_AND;
      FN_OR:   alu_control_c = ALU_OR;
      FN_SLT:  alu_control_c = ALU_SLT;
      default: legal_c       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control.sv
// mips_control: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional feature: define MIPS_CTRL_PERF_EN to enable the retired-instruction
// counter; otherwise retired_count is tied to 0.
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   instr_valid          instruction word present (only sampled in FETCH)
//   opcode, funct        instr[31:26], instr[5:0]
//   zero                 ALU zero flag (branch resolution in EXEC)
//   mem_ready            data-memory access complete
//   reg_write .. jump    datapath controls
//   alu_control          ALU operation
//   mem_read, mem_write  data-memory strobes
//   ir_en, pc_en         instruction-register capture, PC advance
//   halted               sticky error (illegal instruction / memory timeout)
//   retired_count        retired-instruction count
module mips_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        instr_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        reg_write,
  output logic        reg_dest,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        jump,
  output logic [2:0]  alu_control,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_en,
  output logic        pc_en,
  output logic        halted,
  output logic [31:0] retired_count
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  kind_e            kind_q, dec_kind;
  ctrl_t            ctrl_q, dec_ctrl;
  logic             dec_ok;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0] rt_alu;
  logic             rt_ok;

  mips_alu_decoder u_alu_dec (
    .funct         (funct),
    .alu_control_c (rt_alu),
    .legal_c       (rt_ok)
  );

  // Main decoder: instruction class and controls for the word in DECODE
  always_comb begin
    dec_ok   = 1'b1;
    dec_kind = K_RTYPE;
    dec_ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_kind             = K_RTYPE;
        dec_ctrl.reg_dest    = 1'b1;
        dec_ctrl.alu_control = rt_alu;
        dec_ok               = rt_ok;
      end
      OP_LW: begin
        dec_kind             = K_LW;
        dec_ctrl.alu_src     = 1'b1;
        dec_ctrl.mem_to_reg  = 1'b1;
        dec_ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        dec_kind             = K_SW;
        dec_ctrl.alu_src     = 1'b1;
        dec_ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        dec_kind             = K_BEQ;
        dec_ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        dec_kind             = K_ADDI;
        dec_ctrl.alu_src     = 1'b1;
        dec_ctrl.alu_control = ALU_ADD;
      end
      OP_J:    dec_kind = K_J;
      default: dec_ok   = 1'b0;
    endcase
  end

  // State register plus the per-instruction controls and MEM wait counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_FETCH;
      kind_q  <= K_RTYPE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE && dec_ok) begin
        kind_q <= dec_kind;
        ctrl_q <= dec_ctrl;
      end
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_src    = 1'b0;
    jump      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          // state_q sits at FETCH during reset; keep ir_en low there too
          ir_en   = arst_n;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_ok) begin
          state_d = S_HALT;
        end else if (dec_kind == K_J) begin
          jump    = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind_q)
          K_BEQ: begin
            pc_src  = zero;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          K_LW, K_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (kind_q == K_LW);
        mem_write = (kind_q == K_SW);
        if (mem_ready) begin
          if (kind_q == K_LW) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign halted      = (state_q == S_HALT);
  assign reg_dest    = ctrl_q.reg_dest;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_control = ctrl_q.alu_control;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] retired_q;

  // One count per pc_en pulse, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      retired_q <= '0;
    end else if (pc_en) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = 32'd0;
`endif

endmodule
